imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder serving the fetch stage's `imem_addr`/`imem_data` interface. It accepts a held fetch request, waits a fixed number of wait states, and returns one 32-bit word with a single-cycle `ready` strobe. It sits between the fetch stage and the instruction store. It also exposes a load port so the testbench or boot logic can write program words before execution.

## Interface
Parameters:
- `DEPTH`, default 1024: memory size in 32-bit words; must be a power of two, at least 4.
- `WAIT_STATES`, default 1: extra cycles inserted before the response; legal range 0..15.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `req`, in, 1: fetch request; requester holds it, with a stable address, until `ready`.
- `imem_addr`, in, 32: byte address of the instruction to fetch.
- `imem_data`, out, 32: fetched word; registered and valid when `ready`=1.
- `ready`, out, 1: one-cycle strobe marking a completed fetch.
- `fault`, out, 1: qualifies `ready`; the fetch was illegal.
- `busy`, out, 1: high whenever the FSM is not in IDLE.
- `load_en`, in, 1: write a program word this cycle.
- `load_addr`, in, 32: byte address for the load.
- `load_data`, in, 32: word to write.

## Operation
- State machine has three states: IDLE, WAIT, RESP.
- IDLE:
  - If `load_en`=1, write `mem[load_addr[IW+1:2]]` <= `load_data`, where IW = $clog2(DEPTH). Stay in IDLE; `req` is not accepted this cycle. Load has priority.
  - Else if `req`=1, latch `imem_addr` and load the wait counter with `WAIT_STATES`.
    - Go to WAIT if `WAIT_STATES`>0, else go to RESP.
- WAIT: decrement the counter each cycle. When the counter reaches 0, read the array into the data register and go to RESP. If `WAIT_STATES`=0, the read happens on the accepting edge.
- RESP:
  - `ready`=1 for exactly this cycle.
  - Unconditionally return to IDLE.
  - A `req` still high is treated as a new request and is evaluated in IDLE on the next cycle.
- The latched address is used throughout. Changes on `imem_addr` after acceptance are ignored.
- `load_en` outside IDLE is ignored; no write occurs and no error is flagged.
- `imem_data` holds its last value between responses.
- `busy` = (state != IDLE).
- Reset values: state IDLE, `ready`=0, `fault`=0, `busy`=0, `imem_data`=32'h0000_0000, counter 0. Array contents are not cleared.
- Reset in any state aborts the fetch. No `ready` pulse is issued, and the block is in IDLE on the next cycle.

## Timing
- A request is accepted at edge N, in IDLE with `req`=1 and `load_en`=0.
- `ready` is high during cycle N+1+`WAIT_STATES`.
- Minimum request-to-request spacing is `WAIT_STATES`+2 cycles: RESP always passes through IDLE.
- A load takes effect at the edge it is sampled. A fetch of the same word accepted on the next IDLE cycle returns the new data.

## Configuration
- Macro `IMEM_FAULT_CHECK_EN`.
- Defined:
  - A fetch faults if `imem_addr[1:0]` != 0 or the word index `imem_addr[31:2]` >= `DEPTH`.
  - On a fault, the response has `fault`=1 and `imem_data`=32'h0000_0000, with the same latency as a normal fetch.
  - A load whose address is misaligned or out of range is dropped.
- Undefined:
  - `fault` is tied to 0.
  - `addr[1:0]` is ignored and the index wraps modulo `DEPTH` (bits [IW+1:2]), for both fetches and loads.

## Test plan
- Reset mid-WAIT: with `WAIT_STATES`=3, accept a fetch, then assert `reset` two cycles later -> no `ready` pulse; `busy`=0, `imem_data`=0 the next cycle.
- Basic fetch: load 32'hDEAD_BEEF at 0x10, then fetch 0x10 with `WAIT_STATES`=1 -> `ready`=1 exactly 2 cycles after acceptance, `imem_data`=32'hDEAD_BEEF, `fault`=0.
- Load/request collision: `load_en` and `req` high together in IDLE, both addressed to 0x20 with `load_data`=32'h0000_0013 -> write occurs; fetch accepted the next cycle returns 32'h0000_0013.
- Back-to-back fetches with `req` held high: fetch 0x0 then 0x4 with `WAIT_STATES`=0 -> `ready` pulses spaced exactly 2 cycles apart, each 1 cycle wide; address change during WAIT has no effect.
- With `IMEM_FAULT_CHECK_EN`, `DEPTH`=1024:
  - fetch 0x2 -> `fault`=1, `imem_data`=0;
  - fetch 0x1000 -> `fault`=1;
  - without the macro, fetch 0x1000 returns the word stored at 0x0.
- Load ignored while busy: pulse `load_en` to 0x8 during WAIT -> a later fetch of 0x8 returns the old contents.

Source files
------------

// File: rtl/imem_responder.sv
// imem_responder: fixed-latency instruction memory responder for the fetch stage.
// Accepts a held fetch request, inserts WAIT_STATES wait cycles, then returns one
// registered 32-bit word with a single-cycle ready strobe. A load port writes
// program words while the block is idle; a load in the same cycle as a request
// wins and the request is picked up on the following idle cycle.
// Optional feature: define IMEM_FAULT_CHECK_EN to flag misaligned or out-of-range
// fetches (fault=1, data=0) and to drop misaligned or out-of-range loads. Without
// it, fault is tied low and addresses wrap modulo DEPTH words.
//
//   state  | meaning
//   -------+---------------------------------------------------------
//   S_IDLE | waiting for a request; loads accepted here only
//   S_WAIT | request latched, counting down the wait states
//   S_RESP | data register valid, ready strobe high for this cycle

module imem_responder #(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic [31:0] imem_addr,
    output logic [31:0] imem_data,
    output logic        ready,
    output logic        fault,
    output logic        busy,
    input  logic        load_en,
    input  logic [31:0] load_addr,
    input  logic [31:0] load_data
);
    localparam int         IW = $clog2(DEPTH);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [31:0]   mem [DEPTH];
    logic [31:0]   addr_q;
    logic [3:0]    cnt_q;
    logic [31:0]   data_q;
    logic          fault_q;

    logic          accept;
    logic          rd_fire;
    logic          ld_fire;
    logic          last_wait;
    logic [31:0]   rd_addr;
    logic [IW-1:0] rd_idx;
    logic [IW-1:0] ld_idx;
    logic          rd_bad;
    logic          ld_bad;

    // Loads have priority over a request in the same idle cycle.
    assign accept    = (state == S_IDLE) && req && !load_en;
    assign last_wait = (state == S_WAIT) && (cnt_q <= 4'd1);

    // With zero wait states the read happens on the accepting edge, before the
    // latched copy exists, so the live address is used there.
    assign rd_addr = (state == S_IDLE) ? imem_addr : addr_q;
    assign rd_idx  = rd_addr[IW+1:2];
    assign ld_idx  = load_addr[IW+1:2];

`ifdef IMEM_FAULT_CHECK_EN
    assign rd_bad = (rd_addr[1:0] != 2'b00) || ({2'b00, rd_addr[31:2]} >= 32'(DEPTH));
    assign ld_bad = (load_addr[1:0] != 2'b00) || ({2'b00, load_addr[31:2]} >= 32'(DEPTH));
`else
    assign rd_bad = 1'b0;
    assign ld_bad = 1'b0;
    logic unused_addr_bits;
    assign unused_addr_bits = ^{rd_addr, load_addr, fault_q};
`endif

    assign rd_fire = (accept && (WS == 4'd0)) || last_wait;
    assign ld_fire = (state == S_IDLE) && load_en && !ld_bad && !reset;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; RESP always returns through IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nx = (WS == 4'd0) ? S_RESP : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q <= 4'd1) begin
                    state_nx = S_RESP;
                end
            end
            S_RESP:  state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // Outputs decoded from state plus the registered response.
    always_comb begin
        ready     = (state == S_RESP);
        busy      = (state != S_IDLE);
        imem_data = data_q;
`ifdef IMEM_FAULT_CHECK_EN
        fault     = (state == S_RESP) && fault_q;
`else
        fault     = 1'b0;
`endif
    end

    // Latched address, wait down-counter and registered read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            if (accept) begin
                addr_q <= imem_addr;
                cnt_q  <= WS;
            end else if ((state == S_WAIT) && (cnt_q != 4'd0)) begin
                cnt_q <= cnt_q - 4'd1;
            end
            if (rd_fire) begin
                data_q  <= rd_bad ? 32'h0000_0000 : mem[rd_idx];
                fault_q <= rd_bad;
            end
        end
    end

    // Program store write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (ld_fire) begin
            mem[ld_idx] <= load_data;
        end
    end

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances with 0, 1 and 3 wait states,
// a constant vector table, hand-written corner sequences and randomized
// fetch/load traffic checked against a word-array reference model.
`timescale 1ns/1ps
module tb_imem_responder;
    localparam int DEPTH = 1024;
    localparam int NDUT  = 3;
`ifdef IMEM_FAULT_CHECK_EN
    localparam bit FCHK = 1'b1;
`else
    localparam bit FCHK = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_s     [NDUT];
    logic [31:0] addr_s    [NDUT];
    logic        ld_en_s   [NDUT];
    logic [31:0] ld_addr_s [NDUT];
    logic [31:0] ld_data_s [NDUT];
    logic [31:0] data_o    [NDUT];
    logic        ready_o   [NDUT];
    logic        fault_o   [NDUT];
    logic        busy_o    [NDUT];

    logic [31:0] ref_mem [NDUT][DEPTH];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        imem_responder #(
            .DEPTH(DEPTH),
            .WAIT_STATES((g == 0) ? 0 : (g == 1) ? 1 : 3)
        ) u_dut (
            .clk(clk), .reset(reset), .req(req_s[g]), .imem_addr(addr_s[g]),
            .imem_data(data_o[g]), .ready(ready_o[g]), .fault(fault_o[g]),
            .busy(busy_o[g]), .load_en(ld_en_s[g]), .load_addr(ld_addr_s[g]),
            .load_data(ld_data_s[g])
        );
    end

    function automatic int ws_of(input int k);
        case (k)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    function automatic bit addr_bad(input logic [31:0] a);
        bit bad;
        bad = (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
        if (!FCHK) bad = 1'b0;
        return bad;
    endfunction

    function automatic int widx(input logic [31:0] a);
        int unsigned w;
        w = (a >> 2) % DEPTH;
        return int'(w);
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned r;
        logic [31:0] a;
        r = $urandom_range(0, 9);
        a = 32'($urandom_range(0, DEPTH - 1)) << 2;
        if (r == 7) a[1:0] = 2'($urandom_range(1, 3));
        else if (r >= 8) a = $urandom;
        return a;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with instance k idle; returns at a negedge, idle.
    task automatic do_load(input int k, input logic [31:0] a, input logic [31:0] d);
        ld_en_s[k] = 1'b1; ld_addr_s[k] = a; ld_data_s[k] = d;
        @(negedge clk);
        ld_en_s[k] = 1'b0;
        if (!addr_bad(a)) ref_mem[k][widx(a)] = d;
    endtask

    // Issue a fetch of a; after acceptance the address bus moves to alt, and
    // optionally a load to a is attempted while the fetch is in flight.
    task automatic do_fetch(input int k, input logic [31:0] a, input logic [31:0] alt,
                            input bit ld_busy, output logic [31:0] d, output logic f,
                            output int lat);
        d = 'x; f = 1'bx; lat = -1;
        req_s[k] = 1'b1; addr_s[k] = a;
        @(posedge clk);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) addr_s[k] = alt;
            if (c == 2) ld_en_s[k] = 1'b0;
            if (c == 1 && ld_busy && ws_of(k) > 0) begin
                ld_en_s[k] = 1'b1; ld_addr_s[k] = a; ld_data_s[k] = 32'hBAD0_0000 ^ $urandom;
            end
            if (ready_o[k]) begin
                lat = c; d = data_o[k]; f = fault_o[k];
                break;
            end
        end
        req_s[k] = 1'b0; ld_en_s[k] = 1'b0;
        @(negedge clk);
        if (lat > 0) begin
            chk("ready_width", 32'(ready_o[k]), 32'd0);
            chk("data_hold", data_o[k], d);
        end
    endtask

    task automatic check_fetch(input int k, input logic [31:0] a, input logic [31:0] alt,
                               input bit ldb, input string tag);
        logic [31:0] ed, d;
        logic ef, f;
        int lat;
        ef = addr_bad(a);
        ed = ef ? 32'h0 : ref_mem[k][widx(a)];
        do_fetch(k, a, alt, ldb, d, f, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(ws_of(k) + 1));
        chk({tag, "_data"}, d, ed);
        chk({tag, "_fault"}, 32'(f), 32'(ef));
    endtask

    typedef struct {
        bit          do_ld;
        logic [31:0] ld_a;
        logic [31:0] ld_d;
        logic [31:0] f_a;
        logic [31:0] e_d;
        logic        e_f;
    } vec_t;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        vec_t vt[8];
        logic [31:0] d, d1, d2;
        logic f;
        int lat, r1, r2, nrdy, seen;

        vt[0] = '{1'b1, 32'h10,   32'hDEAD_BEEF, 32'h10,   32'hDEAD_BEEF, 1'b0};
        vt[1] = '{1'b1, 32'h0,    32'h1111_1111, 32'h0,    32'h1111_1111, 1'b0};
        vt[2] = '{1'b1, 32'hFFC,  32'hCAFE_F00D, 32'hFFC,  32'hCAFE_F00D, 1'b0};
        vt[3] = '{1'b1, 32'h4,    32'h4444_4444, 32'h4,    32'h4444_4444, 1'b0};
        vt[4] = '{1'b0, 32'h0,    32'h0,         32'h1000, FCHK ? 32'h0 : 32'h1111_1111, FCHK};
        vt[5] = '{1'b0, 32'h0,    32'h0,         32'h2,    FCHK ? 32'h0 : 32'h1111_1111, FCHK};
        vt[6] = '{1'b0, 32'h0,    32'h0,         32'h13,   FCHK ? 32'h0 : 32'hDEAD_BEEF, FCHK};
        vt[7] = '{1'b1, 32'h1004, 32'h7777_7777, 32'h4,    FCHK ? 32'h4444_4444 : 32'h7777_7777, 1'b0};

        for (int k = 0; k < NDUT; k++) begin
            req_s[k] = 1'b0; addr_s[k] = '0; ld_en_s[k] = 1'b0;
            ld_addr_s[k] = '0; ld_data_s[k] = '0;
        end

        // Reset state.
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < NDUT; k++) begin
            chk("rst_ready", 32'(ready_o[k]), 32'd0);
            chk("rst_fault", 32'(fault_o[k]), 32'd0);
            chk("rst_busy",  32'(busy_o[k]),  32'd0);
            chk("rst_data",  data_o[k],       32'd0);
        end

        // Fill every word of every instance so later fetches are defined.
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = 0; k < NDUT; k++) begin
                ld_en_s[k] = 1'b1; ld_addr_s[k] = 32'(i * 4); ld_data_s[k] = $urandom;
                ref_mem[k][i] = ld_data_s[k];
            end
            @(negedge clk);
        end
        for (int k = 0; k < NDUT; k++) ld_en_s[k] = 1'b0;

        // Vector table on the one-wait-state instance.
        for (int i = 0; i < 8; i++) begin
            if (vt[i].do_ld) do_load(1, vt[i].ld_a, vt[i].ld_d);
            do_fetch(1, vt[i].f_a, vt[i].f_a, 1'b0, d, f, lat);
            chk($sformatf("vec%0d_lat", i), 32'(lat), 32'd2);
            chk($sformatf("vec%0d_data", i), d, vt[i].e_d);
            chk($sformatf("vec%0d_fault", i), 32'(f), 32'(vt[i].e_f));
        end

        // Load and request together: load wins, request taken next cycle.
        ld_en_s[1] = 1'b1; ld_addr_s[1] = 32'h20; ld_data_s[1] = 32'h0000_0013;
        req_s[1] = 1'b1; addr_s[1] = 32'h20;
        @(negedge clk);
        ld_en_s[1] = 1'b0;
        ref_mem[1][8] = 32'h0000_0013;
        chk("coll_not_accepted", 32'(busy_o[1]), 32'd0);
        lat = -1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ready_o[1]) begin lat = c; d = data_o[1]; break; end
        end
        req_s[1] = 1'b0;
        @(negedge clk);
        chk("coll_lat", 32'(lat), 32'd2);
        chk("coll_data", d, 32'h0000_0013);

        // Back-to-back with req held, zero wait states.
        r1 = -1; r2 = -1; nrdy = 0; d1 = 'x; d2 = 'x;
        req_s[0] = 1'b1; addr_s[0] = 32'h0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (ready_o[0]) begin
                nrdy++;
                if (r1 < 0) begin
                    r1 = c; d1 = data_o[0]; addr_s[0] = 32'h4;
                end else if (r2 < 0) begin
                    r2 = c; d2 = data_o[0]; req_s[0] = 1'b0;
                end
            end
        end
        req_s[0] = 1'b0;
        chk("b2b_first", 32'(r1), 32'd1);
        chk("b2b_second", 32'(r2), 32'd3);
        chk("b2b_count", 32'(nrdy), 32'd2);
        chk("b2b_data0", d1, ref_mem[0][0]);
        chk("b2b_data1", d2, ref_mem[0][1]);

        // Address change during WAIT, then a load attempted while busy.
        check_fetch(2, 32'h8, 32'hC, 1'b0, "addr_change");
        check_fetch(2, 32'h8, 32'h8, 1'b1, "busy_load");
        check_fetch(2, 32'h8, 32'h8, 1'b0, "after_busy_load");
        check_fetch(1, 32'h8, 32'h8, 1'b1, "busy_load_ws1");
        check_fetch(1, 32'h8, 32'h8, 1'b0, "after_busy_load_ws1");

        // Randomized traffic on all instances.
        for (int k = 0; k < NDUT; k++) begin
            for (int n = 0; n < 120; n++) begin
                if ($urandom_range(0, 2) == 0) do_load(k, rand_addr(), $urandom);
                else check_fetch(k, rand_addr(), rand_addr(), $urandom_range(0, 1) == 1, "rnd");
            end
        end

        // Reset two cycles into a three-wait-state fetch.
        do_load(2, 32'h30, 32'h5A5A_1234);
        check_fetch(2, 32'h30, 32'h30, 1'b0, "pre_reset");
        seen = 0;
        req_s[2] = 1'b1; addr_s[2] = 32'h30;
        @(posedge clk);
        @(negedge clk);
        if (ready_o[2]) seen++;
        chk("midwait_busy", 32'(busy_o[2]), 32'd1);
        @(negedge clk);
        if (ready_o[2]) seen++;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; req_s[2] = 1'b0;
        chk("abort_busy", 32'(busy_o[2]), 32'd0);
        chk("abort_data", data_o[2], 32'd0);
        chk("abort_ready", 32'(ready_o[2]), 32'd0);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (ready_o[2]) seen++;
        end
        chk("abort_no_ready", 32'(seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
